// File: rtl/fsm_trace_checker_pkg.sv
// Shared state codes and legality helper for the sequence-FSM trace checker.
package fsm_trace_checker_pkg;

  localparam logic [2:0] S_A = 3'd2;
  localparam logic [2:0] S_B = 3'd4;
  localparam logic [2:0] S_C = 3'd1;
  localparam logic [2:0] S_D = 3'd6;
  localparam logic [2:0] S_E = 3'd7;

  function automatic logic is_legal(input logic [2:0] code);
    logic legal;
    legal = 1'b0;
    case (code)
      S_A, S_B, S_C, S_D, S_E: legal = 1'b1;
      default:                 legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/fsm_golden_model.sv
// Golden next-state model of the sequence FSM; exp is the code the FSMs should hold now.
module fsm_golden_model
  import fsm_trace_checker_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic       a,
  output logic [2:0] exp
);

  logic [2:0] exp_q;
  logic [2:0] exp_d;

  always_ff @(posedge clk) begin
    if (!res) begin
      exp_q <= S_A;
    end else begin
      exp_q <= exp_d;
    end
  end

  always_comb begin
    exp_d = S_A;
    case (exp_q)
      S_A:     exp_d = S_B;
      S_B:     exp_d = a ? S_C : S_D;
      S_C:     exp_d = S_D;
      S_D:     exp_d = S_E;
      S_E:     exp_d = a ? S_B : S_A;
      default: exp_d = S_A;
    endcase
  end

  always_comb begin
    exp = exp_q;
  end

endmodule

// File: rtl/fsm_trace_checker.sv
// Checks three FSM implementations against a golden model; sticky flags, counters, first-error capture.
module fsm_trace_checker
  import fsm_trace_checker_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned CYC_W = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             a,
  input  logic [2:0]       s0,
  input  logic [2:0]       s1,
  input  logic [2:0]       s2,
  output logic [2:0]       mismatch,
  output logic [2:0]       illegal,
  output logic             ok,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] loop_cnt,
  output logic [CYC_W-1:0] cyc,
  output logic [CYC_W-1:0] first_err_cyc,
  output logic [8:0]       first_err_code,
  output logic             first_valid
);

  logic [2:0] exp;
  logic [2:0] e_mis;
  logic [2:0] e_ill;
  logic       any_err;
  logic       loop_evt;

  logic [2:0]       mismatch_q;
  logic [2:0]       illegal_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] loop_cnt_q;
  logic [CYC_W-1:0] cyc_q;
  logic [CYC_W-1:0] first_err_cyc_q;
  logic [8:0]       first_err_code_q;
  logic             first_valid_q;

  fsm_golden_model u_golden (
    .clk (clk),
    .res (res),
    .a   (a),
    .exp (exp)
  );

  always_comb begin
    e_mis[0] = (s0 != exp);
    e_mis[1] = (s1 != exp);
    e_mis[2] = (s2 != exp);
    e_ill[0] = !is_legal(s0);
    e_ill[1] = !is_legal(s1);
    e_ill[2] = !is_legal(s2);
    any_err  = |(e_mis | e_ill);
    loop_evt = (exp == S_E) && !a;
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      mismatch_q       <= '0;
      illegal_q        <= '0;
      err_cnt_q        <= '0;
      loop_cnt_q       <= '0;
      cyc_q            <= '0;
      first_err_cyc_q  <= '0;
      first_err_code_q <= '0;
      first_valid_q    <= 1'b0;
    end else begin
      mismatch_q <= mismatch_q | e_mis;
      illegal_q  <= illegal_q | e_ill;
      cyc_q      <= cyc_q + CYC_W'(1);
      if (any_err && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
      if (loop_evt && (loop_cnt_q != '1)) begin
        loop_cnt_q <= loop_cnt_q + CNT_W'(1);
      end
      // Capture only the very first errored cycle since reset.
      if (any_err && !first_valid_q) begin
        first_err_cyc_q  <= cyc_q;
        first_err_code_q <= {s2, s1, s0};
        first_valid_q    <= 1'b1;
      end
    end
  end

  always_comb begin
    mismatch       = mismatch_q;
    illegal        = illegal_q;
    ok             = (mismatch_q == 3'b000) && (illegal_q == 3'b000);
    err_cnt        = err_cnt_q;
    loop_cnt       = loop_cnt_q;
    cyc            = cyc_q;
    first_err_cyc  = first_err_cyc_q;
    first_err_code = first_err_code_q;
    first_valid    = first_valid_q;
  end

endmodule

// File: tb/tb_fsm_trace_checker.sv
// Scoreboard bench: stimulus pushes model predictions, monitor pops and compares after each edge.
module tb_fsm_trace_checker;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       a   = 1'b0;
  logic [2:0] s0  = 3'd2;
  logic [2:0] s1  = 3'd2;
  logic [2:0] s2  = 3'd2;

  logic [2:0]  mis_w, ill_w, mis_n, ill_n;
  logic        ok_w, ok_n, fv_w, fv_n;
  logic [7:0]  err_w, loop_w;
  logic [1:0]  err_n, loop_n;
  logic [15:0] cyc_w, fcyc_w;
  logic [3:0]  cyc_n, fcyc_n;
  logic [8:0]  fcode_w, fcode_n;

  always #5 clk = ~clk;

  fsm_trace_checker #(.CNT_W(8), .CYC_W(16)) u_dut (
    .clk (clk), .res (res), .a (a), .s0 (s0), .s1 (s1), .s2 (s2),
    .mismatch (mis_w), .illegal (ill_w), .ok (ok_w), .err_cnt (err_w), .loop_cnt (loop_w),
    .cyc (cyc_w), .first_err_cyc (fcyc_w), .first_err_code (fcode_w), .first_valid (fv_w)
  );

  // Narrow instance: exercises counter saturation and cycle wrap.
  fsm_trace_checker #(.CNT_W(2), .CYC_W(4)) u_dut_n (
    .clk (clk), .res (res), .a (a), .s0 (s0), .s1 (s1), .s2 (s2),
    .mismatch (mis_n), .illegal (ill_n), .ok (ok_n), .err_cnt (err_n), .loop_cnt (loop_n),
    .cyc (cyc_n), .first_err_cyc (fcyc_n), .first_err_code (fcode_n), .first_valid (fv_n)
  );

  typedef struct {
    logic [2:0]  mis;
    logic [2:0]  ill;
    logic        ok;
    logic [7:0]  err8;
    logic [7:0]  loop8;
    logic [15:0] cyc16;
    logic [15:0] fc16;
    logic [8:0]  fcode;
    logic        fv;
    logic [1:0]  err2;
    logic [1:0]  loop2;
    logic [3:0]  cyc4;
    logic [3:0]  fc4;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  int          nxt_a0[8];
  int          nxt_a1[8];
  bit          legal[8];
  int          m_exp   = 2;
  int unsigned m_cyc   = 0;
  int unsigned m_err   = 0;
  int unsigned m_loop  = 0;
  int unsigned m_fcyc  = 0;
  bit [2:0]    m_mis   = '0;
  bit [2:0]    m_ill   = '0;
  bit [8:0]    m_fcode = '0;
  bit          m_fv    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  // One cycle: drive inputs on the falling edge, advance model, queue post-edge expectation.
  task automatic step(input bit r, input bit av, input bit [2:0] d0, input bit [2:0] d1,
                      input bit [2:0] d2, input bit [2:0] fmask);
    bit [2:0] s[3];
    bit [2:0] e_mis, e_ill;
    bit [2:0] cur;
    exp_t     e;
    int unsigned err_s, loop_s;
    @(negedge clk);
    cur  = 3'(m_exp);
    s[0] = fmask[0] ? d0 : cur;
    s[1] = fmask[1] ? d1 : cur;
    s[2] = fmask[2] ? d2 : cur;
    res = r; a = av; s0 = s[0]; s1 = s[1]; s2 = s[2];
    if (!r) begin
      m_exp = 2; m_cyc = 0; m_err = 0; m_loop = 0; m_fcyc = 0;
      m_mis = '0; m_ill = '0; m_fcode = '0; m_fv = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        e_mis[i] = (s[i] != cur);
        e_ill[i] = !legal[s[i]];
      end
      if ((e_mis | e_ill) != 3'b000) begin
        m_err++;
        if (!m_fv) begin
          m_fv = 1'b1; m_fcyc = m_cyc; m_fcode = {s[2], s[1], s[0]};
        end
      end
      m_mis |= e_mis;
      m_ill |= e_ill;
      if (m_exp == 7 && !av) m_loop++;
      m_exp = av ? nxt_a1[m_exp] : nxt_a0[m_exp];
      m_cyc++;
    end
    err_s  = sat(m_err, 255);
    loop_s = sat(m_loop, 255);
    e.mis   = m_mis;
    e.ill   = m_ill;
    e.ok    = (m_mis == 3'b000) && (m_ill == 3'b000);
    e.err8  = err_s[7:0];
    e.loop8 = loop_s[7:0];
    e.cyc16 = m_cyc[15:0];
    e.fc16  = m_fcyc[15:0];
    e.fcode = m_fcode;
    e.fv    = m_fv;
    err_s   = sat(m_err, 3);
    loop_s  = sat(m_loop, 3);
    e.err2  = err_s[1:0];
    e.loop2 = loop_s[1:0];
    e.cyc4  = m_cyc[3:0];
    e.fc4   = m_fcyc[3:0];
    sbq.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("mismatch", 32'(mis_w), 32'(e.mis));
        chk("illegal", 32'(ill_w), 32'(e.ill));
        chk("ok", 32'(ok_w), 32'(e.ok));
        chk("err_cnt", 32'(err_w), 32'(e.err8));
        chk("loop_cnt", 32'(loop_w), 32'(e.loop8));
        chk("cyc", 32'(cyc_w), 32'(e.cyc16));
        chk("first_err_cyc", 32'(fcyc_w), 32'(e.fc16));
        chk("first_err_code", 32'(fcode_w), 32'(e.fcode));
        chk("first_valid", 32'(fv_w), 32'(e.fv));
        chk("n_mismatch", 32'(mis_n), 32'(e.mis));
        chk("n_ok", 32'(ok_n), 32'(e.ok));
        chk("n_err_cnt", 32'(err_n), 32'(e.err2));
        chk("n_loop_cnt", 32'(loop_n), 32'(e.loop2));
        chk("n_cyc", 32'(cyc_n), 32'(e.cyc4));
        chk("n_first_err_cyc", 32'(fcyc_n), 32'(e.fc4));
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      nxt_a0[i] = 2; nxt_a1[i] = 2; legal[i] = 1'b0;
    end
    nxt_a0[2] = 4; nxt_a0[4] = 6; nxt_a0[1] = 6; nxt_a0[6] = 7; nxt_a0[7] = 2;
    nxt_a1[2] = 4; nxt_a1[4] = 1; nxt_a1[1] = 6; nxt_a1[6] = 7; nxt_a1[7] = 4;
    legal[1] = 1'b1; legal[2] = 1'b1; legal[4] = 1'b1; legal[6] = 1'b1; legal[7] = 1'b1;

    // a=0 held, correct FSMs
    repeat (2) step(0, 0, 0, 0, 0, 3'b000);
    repeat (12) step(1, 0, 0, 0, 0, 3'b000);

    // a=1 held, correct FSMs
    repeat (2) step(0, 1, 0, 0, 0, 3'b000);
    repeat (9) step(1, 1, 0, 0, 0, 3'b000);

    // Illegal code on s1 at cyc 3
    repeat (2) step(0, 0, 0, 0, 0, 3'b000);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 3'd5, 0, (i == 3) ? 3'b010 : 3'b000);

    // s0/s2 wrong but legal at cyc 5, s2 wrong again at cyc 9
    repeat (2) step(0, 0, 0, 0, 0, 3'b000);
    for (int i = 0; i < 12; i++)
      step(1, 0, 3'd6, 0, (i == 5) ? 3'd6 : 3'd1,
           (i == 5) ? 3'b101 : ((i == 9) ? 3'b100 : 3'b000));

    // Persistent mismatch for saturation, then reset with sticky state set
    repeat (2) step(0, 0, 0, 0, 0, 3'b000);
    for (int i = 0; i < 6; i++) step(1, 0, (m_exp == 2) ? 3'd4 : 3'd2, 0, 0, 3'b001);
    repeat (2) step(1, 0, 0, 0, 0, 3'b000);
    step(0, 0, 0, 0, 0, 3'b000);
    repeat (20) step(1, 1, 0, 0, 0, 3'b000);

    // Randomized: random a, sparse corruption, occasional reset
    for (int i = 0; i < 600; i++) begin
      bit [2:0] fm;
      fm[0] = ($urandom_range(0, 99) < 3);
      fm[1] = ($urandom_range(0, 99) < 3);
      fm[2] = ($urandom_range(0, 99) < 3);
      step(($urandom_range(0, 99) >= 2), 1'($urandom), 3'($urandom), 3'($urandom),
           3'($urandom), fm);
    end

    repeat (2) @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_trace_checker.md
Name: fsm_trace_checker

Overview:
- Downstream consumer of the 3-bit state/output codes driven by the three sequence-FSM implementations (case-based, gate-level, memory-based).
- Runs its own golden next-state model from the same `a` input and checks each implementation's code every cycle.
- Flags per-implementation mismatches and illegal codes, and counts errors and completed loops.
- Captures the cycle and code of the first error, for bench and waveform triage.

Parameters:
- CNT_W, 8, width of the saturating error and loop counters
- CYC_W, 16, width of the free-running cycle counter and the first-error timestamp

Ports:
- clk  in  1  system clock, rising edge
- res  in  1  synchronous active-low reset
- a  in  1  same `a` stimulus that drives the FSMs, sampled on the same edge
- s0  in  3  code from the case-based FSM
- s1  in  3  code from the gate-level FSM
- s2  in  3  code from the memory-based FSM
- mismatch  out  3  sticky; bit i set when s_i differed from the expected code
- illegal  out  3  sticky; bit i set when s_i held a code outside {1,2,4,6,7}
- ok  out  1  high while mismatch==0 and illegal==0
- err_cnt  out  CNT_W  number of cycles with at least one error, saturating
- loop_cnt  out  CNT_W  number of expected transitions 7->2, saturating
- cyc  out  CYC_W  cycles since reset release, wrapping
- first_err_cyc  out  CYC_W  value of cyc at the first error
- first_err_code  out  9  {s2,s1,s0} captured at the first error
- first_valid  out  1  first-error capture is valid

Behaviour:
- Clock and reset: one clock, clk. Reset res is synchronous and active-low: sampled only on the rising edge of clk.
- On reset (res==0 at a posedge):
  - exp <= 3'd2.
  - cyc, err_cnt, loop_cnt, mismatch, illegal, first_err_cyc, first_err_code <= 0.
  - first_valid <= 0.
  - No check is performed on that edge.
  - After reset, ok=1.
- Golden model, with exp as the current expected code:
  - 2 -> 4
  - 4 -> 1 if a==1, else 6
  - 1 -> 6
  - 6 -> 7
  - 7 -> 4 if a==1, else 2
  - Any other exp value (unreachable) -> 2
- Check timing, on each posedge with res==1:
  - Compare the pre-edge s_i against the pre-edge exp. The FSMs update on the same edge, so the sampled s_i is their current state.
  - Then exp <= next(exp,a) and cyc <= cyc+1 (wraps modulo 2^CYC_W).
  - Latency: an error present before edge k is visible on the outputs after edge k (one cycle).
- Error rules, per bit i:
  - e_mis[i] = (s_i != exp).
  - e_ill[i] = s_i not in {1,2,4,6,7}.
  - mismatch |= e_mis; illegal |= e_ill. Both are sticky until reset.
  - An illegal code is always also a mismatch.
  - If any error bit is set this cycle: err_cnt <= err_cnt+1, saturating at 2^CNT_W-1.
- First-error capture:
  - On the first errored cycle with first_valid==0: first_err_cyc <= cyc (pre-increment), first_err_code <= {s2,s1,s0}, first_valid <= 1.
  - Later errors do not overwrite the capture.
- Loop counting: loop_cnt increments when exp==7, a==0 and res==1. It saturates and counts independently of errors.
- Simultaneous events:
  - Several s_i wrong in the same cycle -> all corresponding bits are set and err_cnt increments by exactly 1.
  - A loop completion and an error in the same cycle -> both counters update.
- Reset mid-operation: everything reloads on the next edge. The golden model restarts at 2 and must stay aligned with the FSMs, which are also reset to 2.
- No internal recovery: after a mismatch, exp keeps following the golden path and ignores the DUT codes.

Decomposition:
- Shared package: code constants S_A=2, S_B=4, S_C=1, S_D=6, S_E=7 and a legality function.
- One natural sub-module: fsm_golden_model, containing the exp register and next-state logic (clk, res, a -> exp). The checker instantiates it and adds comparison, sticky flags, counters and capture.

Test Plan:
- Reset, then a=0 held for 12 cycles with correct FSMs -> exp sequence 2,4,6,7,2,4,6,7,2,...; ok=1; err_cnt=0; loop_cnt=3 after 12 checked cycles.
- Reset, then a=1 held -> sequence 2,4,1,6,7,4,1,6,7; loop_cnt stays 0; no errors.
- Force s1=3'd5 for one cycle at cyc=3 -> mismatch=3'b010, illegal=3'b010; err_cnt=1; first_err_cyc=3; first_err_code[5:3]=5; first_valid=1; ok=0 thereafter.
- Force s0 and s2 to 3'd6 while exp==4 at cyc=5, then s2 wrong again at cyc=9 -> mismatch=3'b101, illegal=0; err_cnt=2; first_err_cyc stays 5.
- With CNT_W=2, force a persistent mismatch for 6 cycles -> err_cnt saturates at 3.
- Pull res low mid-sequence with sticky errors set -> all outputs are 0 and ok=1 after the next edge; exp restarts at 2.
